// File: rtl/eprom8755_pkg.sv
// Shared constants, state encoding and the EPROM bit-clearing helper for the
// 8755 EPROM bus responder model.
package eprom8755_pkg;

   localparam int unsigned ADDR_W = 11;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 2048;
   localparam logic [DATA_W-1:0] ERASED = 8'hFF;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      READ  = 3'd2,
      PROG  = 3'd3,
      ERASE = 3'd4
   } state_t;

   // An EPROM cell can only be driven from 1 to 0 by programming.
   function automatic logic [DATA_W-1:0] prog_merge(input logic [DATA_W-1:0] cur,
                                                    input logic [DATA_W-1:0] wr);
      return cur & wr;
   endfunction

endpackage

// File: rtl/eprom8755_emulator_ctr.sv
// Saturating cycle counter that clears whenever its enable is low.
module emu_cycle_ctr #(
   parameter int unsigned W   = 4,
   parameter int unsigned MAX = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         en_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   localparam logic [W-1:0] MAX_C = W'(MAX);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (!en_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != MAX_C)) begin
         count_d = count_q + W'(1);
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/eprom8755_emulator.sv
// 2K x 8 EPROM model answering the 8755 multiplexed ALE/CE/RD/data-latch bus.
// Define EMU8755_PROG_EN to compile in the program path; otherwise read-only.
module eprom8755_emulator
   import eprom8755_pkg::*;
#(
   parameter int unsigned READ_LAT        = 2,
   parameter int unsigned PROG_MIN_CYCLES = 1000100
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              ale_i,
   input  logic              ce_i,
   input  logic              rd_n_i,
   input  logic              data_latch_n_i,
   input  logic [ADDR_W-1:0] ad_in_i,
   input  logic              erase_i,
   output logic [DATA_W-1:0] ad_out_o,
   output logic              ad_oe_o,
   output logic              busy_o,
   output logic              prog_done_o,
   output logic              prog_err_o
);

   localparam int unsigned       RD_W   = $clog2(READ_LAT + 1);
   localparam logic [RD_W-1:0]   RD_HIT = RD_W'(READ_LAT - 1);
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

   state_t              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W-1:0]   erase_addr_q;
   logic [DATA_W-1:0]   ad_out_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                ad_oe_q;
   logic                busy_q;
   logic                prog_done_q;
   logic                prog_err_q;
   logic                dl_hold_q;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                mem_we_s;
   logic [ADDR_W-1:0]   mem_waddr_s;
   logic [DATA_W-1:0]   mem_wdata_s;
   logic [RD_W-1:0]     rd_cnt_s;
   logic                rd_en_s;
   logic                prog_commit_s;

   assign rd_en_s = (state_q == READ);

   emu_cycle_ctr #(
      .W   (RD_W),
      .MAX (READ_LAT)
   ) u_rd_ctr (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (rd_en_s),
      .inc_i   (1'b1),
      .count_o (rd_cnt_s)
   );

`ifdef EMU8755_PROG_EN
   localparam int unsigned     PG_W   = $clog2(PROG_MIN_CYCLES + 1);
   localparam logic [PG_W-1:0] PG_HIT = PG_W'(PROG_MIN_CYCLES - 1);

   logic [DATA_W-1:0] pdata_q;
   logic [PG_W-1:0]   pg_cnt_s;
   logic              pg_en_s;
   logic              pg_inc_s;
   logic              pg_release_s;
   logic              pg_ok_s;

   // The entry cycle is part of the pulse, so PG_HIT counted cycles plus entry meets the minimum.
   assign pg_en_s       = (state_q == PROG);
   assign pg_inc_s      = ~data_latch_n_i & ce_i;
   assign pg_release_s  = data_latch_n_i | ~ce_i;
   assign pg_ok_s       = (pg_cnt_s >= PG_HIT);
   assign prog_commit_s = pg_en_s & ~ale_i & pg_release_s & pg_ok_s;

   emu_cycle_ctr #(
      .W   (PG_W),
      .MAX (PROG_MIN_CYCLES)
   ) u_pg_ctr (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (pg_en_s),
      .inc_i   (pg_inc_s),
      .count_o (pg_cnt_s)
   );

   assign prog_done_o = prog_done_q;
`else
   assign prog_commit_s = 1'b0;
   assign prog_done_o   = 1'b0;
`endif

   // Array write port selection: erase sweep or program commit.
   always_comb begin
      mem_we_s    = 1'b0;
      mem_waddr_s = erase_addr_q;
      mem_wdata_s = ERASED;
      if (state_q == ERASE) begin
         mem_we_s = 1'b1;
      end else if (prog_commit_s) begin
         mem_we_s    = 1'b1;
         mem_waddr_s = addr_q;
`ifdef EMU8755_PROG_EN
         mem_wdata_s = prog_merge(rdata_q, pdata_q);
`endif
      end else begin
         mem_we_s = 1'b0;
      end
   end

   // Array storage with synchronous read; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (mem_we_s) begin
         mem_q[mem_waddr_s] <= mem_wdata_s;
      end
      rdata_q <= mem_q[addr_q];
   end

   // Bus cycle state machine with registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         erase_addr_q <= '0;
         ad_out_q     <= '0;
         ad_oe_q      <= 1'b0;
         busy_q       <= 1'b0;
         prog_done_q  <= 1'b0;
         prog_err_q   <= 1'b0;
         dl_hold_q    <= 1'b0;
`ifdef EMU8755_PROG_EN
         pdata_q      <= '0;
`endif
      end else begin
         prog_done_q <= 1'b0;
         prog_err_q  <= 1'b0;
         if (data_latch_n_i) begin
            dl_hold_q <= 1'b0;
         end
         if (ale_i && (state_q != ERASE)) begin
            addr_q <= ad_in_i;
         end
         case (state_q)
            IDLE: begin
               if (ale_i) begin
                  state_q <= ADDR;
               end else if (erase_i) begin
                  state_q      <= ERASE;
                  busy_q       <= 1'b1;
                  erase_addr_q <= '0;
               end else if (!rd_n_i && !data_latch_n_i) begin
                  if (!dl_hold_q) begin
                     prog_err_q <= 1'b1;
                     dl_hold_q  <= 1'b1;
                  end
               end else if (!rd_n_i && !ce_i) begin
                  state_q <= READ;
               end else if (!data_latch_n_i && ce_i && !dl_hold_q) begin
`ifdef EMU8755_PROG_EN
                  state_q <= PROG;
                  pdata_q <= ad_in_i[DATA_W-1:0];
`else
                  prog_err_q <= 1'b1;
                  dl_hold_q  <= 1'b1;
`endif
               end
            end
            ADDR: begin
               if (!ale_i) begin
                  state_q <= IDLE;
               end
            end
            READ: begin
               if (ale_i) begin
                  state_q <= ADDR;
                  ad_oe_q <= 1'b0;
               end else if (rd_n_i || ce_i) begin
                  state_q <= IDLE;
                  ad_oe_q <= 1'b0;
               end else if (rd_cnt_s >= RD_HIT) begin
                  ad_oe_q  <= 1'b1;
                  ad_out_q <= rdata_q;
               end
            end
`ifdef EMU8755_PROG_EN
            PROG: begin
               if (ale_i) begin
                  state_q    <= ADDR;
                  prog_err_q <= 1'b1;
                  dl_hold_q  <= ~data_latch_n_i;
               end else if (pg_release_s) begin
                  state_q     <= IDLE;
                  prog_done_q <= pg_ok_s;
                  prog_err_q  <= ~pg_ok_s;
                  dl_hold_q   <= ~data_latch_n_i;
               end
            end
`endif
            ERASE: begin
               erase_addr_q <= erase_addr_q + ADDR_W'(1);
               if (erase_addr_q == LAST_A) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               ad_oe_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ad_out_o   = ad_out_q;
   assign ad_oe_o    = ad_oe_q;
   assign busy_o     = busy_q;
   assign prog_err_o = prog_err_q;

endmodule

// File: tb/tb_eprom8755_emulator.sv
// Directed, table-driven bench for eprom8755_emulator (PROG_MIN_CYCLES=8, READ_LAT=2).
module tb_eprom8755_emulator;

`ifdef EMU8755_PROG_EN
   localparam bit PROG_ON = 1'b1;
`else
   localparam bit PROG_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ale;
   logic        ce;
   logic        rd_n;
   logic        dl_n;
   logic [10:0] ad_in;
   logic        erase;
   logic [7:0]  ad_out;
   logic        ad_oe;
   logic        busy;
   logic        prog_done;
   logic        prog_err;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   eprom8755_emulator #(
      .READ_LAT        (2),
      .PROG_MIN_CYCLES (8)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .ale_i          (ale),
      .ce_i           (ce),
      .rd_n_i         (rd_n),
      .data_latch_n_i (dl_n),
      .ad_in_i        (ad_in),
      .erase_i        (erase),
      .ad_out_o       (ad_out),
      .ad_oe_o        (ad_oe),
      .busy_o         (busy),
      .prog_done_o    (prog_done),
      .prog_err_o     (prog_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] addr;
      logic [7:0]  data;
      int          width;
      logic [7:0]  exp_rd;
      logic        exp_done;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic latch_addr(input logic [10:0] a);
      ale   = 1'b1;
      ad_in = a;
      tick();
      ale   = 1'b0;
      ad_in = 11'h000;
      tick();
   endtask

   task automatic do_read(input logic [10:0] a, input logic [7:0] exp);
      latch_addr(a);
      rd_n = 1'b0;
      ce   = 1'b0;
      tick();
      chk("rd_oe_lat0", {31'd0, ad_oe}, 32'd0);
      tick();
      chk("rd_oe_lat1", {31'd0, ad_oe}, 32'd0);
      tick();
      chk("rd_oe_lat2", {31'd0, ad_oe}, 32'd1);
      chk("rd_data", {24'd0, ad_out}, {24'd0, exp});
      rd_n = 1'b1;
      tick();
      chk("rd_oe_fall", {31'd0, ad_oe}, 32'd0);
      chk("rd_data_hold", {24'd0, ad_out}, {24'd0, exp});
      tick();
   endtask

   task automatic do_prog(input logic [10:0] a, input logic [7:0] d, input int w,
                          input logic exp_done);
      int n_done = 0;
      int n_err  = 0;
      latch_addr(a);
      ce    = 1'b1;
      dl_n  = 1'b0;
      ad_in = {3'b000, d};
      for (int i = 0; i < w; i++) begin
         tick();
         n_done += int'(prog_done);
         n_err  += int'(prog_err);
      end
      dl_n  = 1'b1;
      ad_in = 11'h000;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_done += int'(prog_done);
         n_err  += int'(prog_err);
      end
      ce = 1'b0;
      chk("prog_done_cnt", n_done, exp_done ? 32'd1 : 32'd0);
      chk("prog_err_cnt", n_err, exp_done ? 32'd0 : 32'd1);
   endtask

   initial begin
      int n;
      int n_err;
      vecs[0] = '{11'h0FF, 8'h5A, 10, PROG_ON ? 8'h5A : 8'hFF, PROG_ON};
      vecs[1] = '{11'h0FF, 8'hF0, 10, PROG_ON ? 8'h50 : 8'hFF, PROG_ON};
      vecs[2] = '{11'h0FF, 8'h00, 5,  PROG_ON ? 8'h50 : 8'hFF, 1'b0};
      vecs[3] = '{11'h7F0, 8'h3C, 9,  PROG_ON ? 8'h3C : 8'hFF, PROG_ON};
      vecs[4] = '{11'h000, 8'hA5, 7,  8'hFF,                   1'b0};
      vecs[5] = '{11'h7FF, 8'h0F, 12, PROG_ON ? 8'h0F : 8'hFF, PROG_ON};
      vecs[6] = '{11'h7FF, 8'h33, 10, PROG_ON ? 8'h03 : 8'hFF, PROG_ON};

      rst_n = 1'b0;
      ale   = 1'b0;
      ce    = 1'b0;
      rd_n  = 1'b1;
      dl_n  = 1'b1;
      ad_in = 11'h000;
      erase = 1'b0;
      #12;
      chk("rst_ad_oe", {31'd0, ad_oe}, 32'd0);
      chk("rst_ad_out", {24'd0, ad_out}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, prog_done}, 32'd0);
      chk("rst_err", {31'd0, prog_err}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Full erase: busy for exactly 2048 cycles.
      erase = 1'b1;
      tick();
      erase = 1'b0;
      chk("erase_busy_hi", {31'd0, busy}, 32'd1);
      n = 0;
      while (busy && n < 3000) begin
         tick();
         n++;
      end
      chk("erase_busy_len", n, 32'd2048);
      do_read(11'h7F0, 8'hFF);
      do_read(11'h123, 8'hFF);

      for (int i = 0; i < 7; i++) begin
         do_prog(vecs[i].addr, vecs[i].data, vecs[i].width, vecs[i].exp_done);
         do_read(vecs[i].addr, vecs[i].exp_rd);
      end

      // Read and program strobes together.
      rd_n = 1'b0;
      dl_n = 1'b0;
      ce   = 1'b0;
      tick();
      chk("conflict_err", {31'd0, prog_err}, 32'd1);
      chk("conflict_oe0", {31'd0, ad_oe}, 32'd0);
      tick();
      chk("conflict_err_once", {31'd0, prog_err}, 32'd0);
      chk("conflict_oe1", {31'd0, ad_oe}, 32'd0);
      rd_n = 1'b1;
      dl_n = 1'b1;
      tick();

      // rd_n low at program level is ignored.
      rd_n = 1'b0;
      ce   = 1'b1;
      tick();
      tick();
      tick();
      chk("rd_ce1_oe", {31'd0, ad_oe}, 32'd0);
      chk("rd_ce1_err", {31'd0, prog_err}, 32'd0);
      rd_n = 1'b1;
      ce   = 1'b0;
      tick();

      // ale rising during a program pulse aborts without writing.
      latch_addr(11'h123);
      ce    = 1'b1;
      dl_n  = 1'b0;
      ad_in = 11'h000;
      n_err = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_err += int'(prog_err);
      end
      ale   = 1'b1;
      ad_in = 11'h123;
      tick();
      n_err += int'(prog_err);
      ale  = 1'b0;
      dl_n = 1'b1;
      ce   = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         n_err += int'(prog_err);
      end
      chk("abort_err_cnt", n_err, 32'd1);
      do_read(11'h123, 8'hFF);

      // Asynchronous reset while driving read data.
      latch_addr(11'h0FF);
      rd_n = 1'b0;
      ce   = 1'b0;
      tick();
      tick();
      tick();
      chk("mid_read_oe", {31'd0, ad_oe}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_oe", {31'd0, ad_oe}, 32'd0);
      chk("async_rst_out", {24'd0, ad_out}, 32'd0);
      rd_n = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      do_read(11'h0FF, PROG_ON ? 8'h50 : 8'hFF);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
